dm_preloader: RTL and testbench

- Hardware writer that fills data memory from a word stream before the CPU runs, replacing bench-side hierarchical backdoor writes into the data-memory array.
- Sits between a host/bench stream source and the data-memory write port.
- Holds the multi-core CPU in stall until the load completes, then releases it.

---
 rtl/dm_preloader.sv | 133 +++++++++++++
 tb/tb_dm_preloader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_preloader.sv
// rtl/dm_preloader.sv - stream-to-data-memory preloader that holds the CPU in stall until the load completes
//
// Ports:
//   clk, reset           system clock, asynchronous active-high reset
//   start                one-cycle load request, sampled only in IDLE
//   base_addr, count     first word address and word count, sampled with start
//   in_valid, in_data    incoming word stream
//   in_ready             word accepted this cycle (LOAD with words remaining)
//   dm_we, dm_addr,      registered data-memory write port, one cycle after
//   dm_wdata             each accepted word
//   cpu_hold             CPU stall, high from reset until the first done
//   busy                 high while in LOAD
//   done                 one-cycle pulse in FINISH
//   checksum             sum of accepted words (only with DM_PRELOADER_CHECKSUM_EN)
//
// Optional feature macro: DM_PRELOADER_CHECKSUM_EN

module dm_preloader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  count,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  dm_we,
    output logic [ADDR_WIDTH-1:0] dm_addr,
    output logic [DATA_WIDTH-1:0] dm_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done
`ifdef DM_PRELOADER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [CNT_WIDTH-1:0]   remaining;
    logic                   hold_q;
    logic                   xfer;
    logic                   accept_start;

    assign xfer         = in_valid && in_ready;
    assign accept_start = (state_q == S_IDLE) && start;

    // hold_q remembers "no load has finished yet"; the FINISH cycle itself
    // already drops cpu_hold so the CPU is released together with done.
    assign cpu_hold = hold_q && (state_q != S_FINISH);

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (count == '0) ? S_FINISH : S_LOAD;
                end
            end
            S_LOAD: begin
                busy     = 1'b1;
                in_ready = (remaining != '0);
                if (xfer && (remaining == CNT_ONE)) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            remaining <= '0;
            hold_q    <= 1'b1;
            dm_we     <= 1'b0;
            dm_addr   <= '0;
            dm_wdata  <= '0;
        end else begin
            state_q <= state_d;
            dm_we   <= xfer;
            if (accept_start) begin
                addr_q    <= base_addr;
                remaining <= count;
            end else if (xfer) begin
                // addr_q wraps naturally at 2^ADDR_WIDTH
                addr_q    <= addr_q + 1'b1;
                remaining <= remaining - CNT_ONE;
            end
            if (xfer) begin
                dm_addr  <= addr_q;
                dm_wdata <= in_data;
            end
            if (state_q == S_FINISH) begin
                hold_q <= 1'b0;
            end
        end
    end

`ifdef DM_PRELOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum <= '0;
        end else if (accept_start) begin
            checksum <= '0;
        end else if (xfer) begin
            checksum <= checksum + in_data;
        end
    end
`endif

endmodule

// File: tb/tb_dm_preloader.sv
// tb/tb_dm_preloader.sv - directed self-checking bench for dm_preloader
module tb_dm_preloader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] count;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        dm_we;
    logic [9:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
`ifdef DM_PRELOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int rdy_cnt = 0;
    int done_cyc = 0;
    int wq_addr[$];
    int wq_data[$];
    int wq_cyc[$];

    dm_preloader dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done)
`ifdef DM_PRELOADER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Write/done log sampled mid-cycle, acting as the data-memory side.
    always @(negedge clk) begin
        if (dm_we) begin
            wq_addr.push_back(int'(dm_addr));
            wq_data.push_back(int'(dm_wdata));
            wq_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (in_ready) rdy_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
    endtask

    // Called at posedge+1; leaves the bench at posedge+1 after the start edge.
    task automatic start_load(input int b, input int n);
        start = 1'b1;
        base_addr = 10'(b);
        count = 11'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic push_word(input logic v, input int d);
        in_valid = v;
        in_data = 32'(d);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; base_addr = '0; count = '0;
        in_valid = 1'b0; in_data = '0;
        #3;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (dm_we !== 1'b0) begin failures++; $display("FAIL reset_dm_we: got %b expected 0", dm_we); end
        checks++; if (dm_addr !== 10'd0) begin failures++; $display("FAIL reset_dm_addr: got %0d expected 0", dm_addr); end
        checks++; if (dm_wdata !== 32'd0) begin failures++; $display("FAIL reset_dm_wdata: got %0h expected 0", dm_wdata); end
        checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL reset_cpu_hold: got %b expected 1", cpu_hold); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
`ifdef DM_PRELOADER_CHECKSUM_EN
        checks++; if (checksum !== 32'd0) begin failures++; $display("FAIL reset_checksum: got %0d expected 0", checksum); end
`endif
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int d0;
        clear_log();
        d0 = done_cnt;
        start_load(0, 10);
        checks++; if (in_ready !== 1'b1 || busy !== 1'b1 || cpu_hold !== 1'b1) begin failures++; $display("FAIL basic_load_entry: got rdy=%b busy=%b hold=%b expected 1 1 1", in_ready, busy, cpu_hold); end
        for (int i = 1; i <= 10; i++) push_word(1'b1, i);
        in_valid = 1'b0;
        checks++; if (dm_we !== 1'b1 || dm_addr !== 10'd9 || dm_wdata !== 32'd10) begin failures++; $display("FAIL basic_last_write: got we=%b a=%0d d=%0d expected 1 9 10", dm_we, dm_addr, dm_wdata); end
        checks++; if (done !== 1'b1 || cpu_hold !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL basic_finish: got done=%b hold=%b rdy=%b expected 1 0 0", done, cpu_hold, in_ready); end
`ifdef DM_PRELOADER_CHECKSUM_EN
        checks++; if (checksum !== 32'd55) begin failures++; $display("FAIL basic_checksum: got %0d expected 55", checksum); end
`endif
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || dm_we !== 1'b0 || busy !== 1'b0 || cpu_hold !== 1'b0) begin failures++; $display("FAIL basic_idle: got done=%b we=%b busy=%b hold=%b expected 0 0 0 0", done, dm_we, busy, cpu_hold); end
`ifdef DM_PRELOADER_CHECKSUM_EN
        checks++; if (checksum !== 32'd55) begin failures++; $display("FAIL basic_checksum_hold: got %0d expected 55", checksum); end
`endif
        checks++; if (wq_addr.size() != 10) begin failures++; $display("FAIL basic_write_count: got %0d expected 10", wq_addr.size()); end
        else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (wq_addr[i] != i || wq_data[i] != i + 1 || wq_cyc[i] != wq_cyc[0] + i) begin
                    failures++;
                    $display("FAIL basic_write_%0d: got a=%0d d=%0d c=%0d expected a=%0d d=%0d c=%0d", i, wq_addr[i], wq_data[i], wq_cyc[i], i, i + 1, wq_cyc[0] + i);
                end
            end
            checks++; if (done_cyc != wq_cyc[9]) begin failures++; $display("FAIL basic_done_cycle: got %0d expected %0d", done_cyc, wq_cyc[9]); end
        end
        checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_backpressure();
        clear_log();
        start_load(4, 3);
        push_word(1'b1, 7);
        checks++; if (dm_we !== 1'b1 || dm_addr !== 10'd4 || dm_wdata !== 32'd7) begin failures++; $display("FAIL bp_w0: got we=%b a=%0d d=%0d expected 1 4 7", dm_we, dm_addr, dm_wdata); end
        push_word(1'b0, 32'hdead);
        checks++; if (dm_we !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL bp_bubble1: got we=%b busy=%b expected 0 1", dm_we, busy); end
        push_word(1'b0, 32'hbeef);
        checks++; if (dm_we !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL bp_bubble2: got we=%b busy=%b expected 0 1", dm_we, busy); end
        push_word(1'b1, 8);
        checks++; if (dm_we !== 1'b1 || dm_addr !== 10'd5 || dm_wdata !== 32'd8 || busy !== 1'b1) begin failures++; $display("FAIL bp_w1: got we=%b a=%0d d=%0d busy=%b expected 1 5 8 1", dm_we, dm_addr, dm_wdata, busy); end
        push_word(1'b1, 9);
        in_valid = 1'b0;
        checks++; if (dm_we !== 1'b1 || dm_addr !== 10'd6 || dm_wdata !== 32'd9 || done !== 1'b1) begin failures++; $display("FAIL bp_w2: got we=%b a=%0d d=%0d done=%b expected 1 6 9 1", dm_we, dm_addr, dm_wdata, done); end
`ifdef DM_PRELOADER_CHECKSUM_EN
        checks++; if (checksum !== 32'd24) begin failures++; $display("FAIL bp_checksum: got %0d expected 24", checksum); end
`endif
        @(posedge clk); #1;
        checks++; if (wq_addr.size() != 3) begin failures++; $display("FAIL bp_write_count: got %0d expected 3", wq_addr.size()); end
    endtask

    task automatic test_zero_count();
        int d0, r0;
        clear_log();
        d0 = done_cnt;
        r0 = rdy_cnt;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL zero_pre_done: got %b expected 0", done); end
        start_load(0, 0);
        checks++; if (done !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL zero_done: got done=%b rdy=%b expected 1 0", done, in_ready); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL zero_done_width: got %b expected 0", done); end
        @(posedge clk); #1;
        checks++; if (wq_addr.size() != 0 || done_cnt - d0 != 1 || rdy_cnt != r0) begin failures++; $display("FAIL zero_activity: got writes=%0d dones=%0d rdy=%0d expected 0 1 0", wq_addr.size(), done_cnt - d0, rdy_cnt - r0); end
    endtask

    task automatic test_wrap();
        int ea[3];
        int ed[3];
        ea = '{1023, 0, 1};
        ed = '{32'h0A, 32'h0B, 32'h0C};
        clear_log();
        start_load(1023, 3);
        push_word(1'b1, 32'h0A);
        push_word(1'b1, 32'h0B);
        push_word(1'b1, 32'h0C);
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (wq_addr.size() != 3) begin failures++; $display("FAIL wrap_count: got %0d expected 3", wq_addr.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wq_addr[i] != ea[i] || wq_data[i] != ed[i]) begin failures++; $display("FAIL wrap_w%0d: got a=%0d d=%0h expected a=%0d d=%0h", i, wq_addr[i], wq_data[i], ea[i], ed[i]); end
            end
        end
    endtask

    task automatic test_start_ignored();
        int d0;
        clear_log();
        d0 = done_cnt;
        start_load(0, 5);
        push_word(1'b1, 50);
        push_word(1'b1, 51);
        start = 1'b1; base_addr = 10'd100; count = 11'd7;
        push_word(1'b1, 52);
        start = 1'b0;
        push_word(1'b1, 53);
        push_word(1'b1, 54);
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (wq_addr.size() != 5 || done_cnt - d0 != 1) begin failures++; $display("FAIL ign_count: got writes=%0d dones=%0d expected 5 1", wq_addr.size(), done_cnt - d0); end
        else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (wq_addr[i] != i || wq_data[i] != 50 + i) begin failures++; $display("FAIL ign_w%0d: got a=%0d d=%0d expected a=%0d d=%0d", i, wq_addr[i], wq_data[i], i, 50 + i); end
            end
        end
    endtask

    task automatic test_reset_mid_load();
        start_load(0, 5);
        push_word(1'b1, 11);
        push_word(1'b1, 12);
        checks++; if (dm_we !== 1'b1 || dm_addr !== 10'd1) begin failures++; $display("FAIL rst_pre: got we=%b a=%0d expected 1 1", dm_we, dm_addr); end
        #2 reset = 1'b1;
        #1;
        checks++; if (dm_we !== 1'b0 || dm_addr !== 10'd0 || dm_wdata !== 32'd0) begin failures++; $display("FAIL rst_async_dm: got we=%b a=%0d d=%0d expected 0 0 0", dm_we, dm_addr, dm_wdata); end
        checks++; if (cpu_hold !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rst_async_ctl: got hold=%b busy=%b rdy=%b done=%b expected 1 0 0 0", cpu_hold, busy, in_ready, done); end
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        clear_log();
        start_load(0, 5);
        for (int i = 0; i < 5; i++) push_word(1'b1, 21 + i);
        in_valid = 1'b0;
        checks++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin failures++; $display("FAIL rst_reload_done: got done=%b hold=%b expected 1 0", done, cpu_hold); end
        @(posedge clk); #1;
        checks++; if (wq_addr.size() != 5) begin failures++; $display("FAIL rst_reload_count: got %0d expected 5", wq_addr.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (wq_addr[i] != i || wq_data[i] != 21 + i) begin failures++; $display("FAIL rst_reload_w%0d: got a=%0d d=%0d expected a=%0d d=%0d", i, wq_addr[i], wq_data[i], i, 21 + i); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_count();
        test_wrap();
        test_start_ignored();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
